// File: rtl/row_cfg_seq.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | row_cfg_seq : sweeps every sensor row, reads N_TAPS pixel flags,    |
// | writes one combined row-enable bit per row, then requests the key. |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
module row_cfg_seq #(
    parameter int N_ROWS  = 16,
    parameter int ROW_W   = 4,
    parameter int N_TAPS  = 2,
    parameter int TAP_W   = 3,
    parameter int RD_LAT  = 2,
    parameter int MODE    = 0,
    parameter int ROW_ASC = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_go,
    input  logic             i_abort,
    input  logic             i_pixel_valid,
    input  logic             i_write_done,
    input  logic             i_key_write_done,
    output logic             o_mem_read,
    output logic [ROW_W-1:0] o_row_idx,
    output logic [TAP_W-1:0] o_tap_idx,
    output logic             o_row_wren,
    output logic             o_row_val,
    output logic             o_key_wren,
    output logic             o_busy,
    output logic             o_done,
    output logic [ROW_W:0]   o_ones_cnt
);

    localparam logic [ROW_W-1:0] START_ROW = (ROW_ASC != 0) ? ROW_W'(0) : ROW_W'(N_ROWS - 1);
    localparam logic [ROW_W-1:0] LAST_ROW  = (ROW_ASC != 0) ? ROW_W'(N_ROWS - 1) : ROW_W'(0);
    localparam logic [TAP_W-1:0] LAST_TAP  = TAP_W'(N_TAPS - 1);
    localparam logic [2:0]       LAST_LAT  = 3'(RD_LAT - 1);
    localparam logic [TAP_W:0]   HALF_TAPS = (TAP_W + 1)'(N_TAPS / 2);

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WAIT_WR   = 4'd1,
        S_RD        = 4'd2,
        S_CMP       = 4'd3,
        S_WRITE     = 4'd4,
        S_NEXT      = 4'd5,
        S_WAIT_IDLE = 4'd6,
        S_KEY_REQ   = 4'd7,
        S_KEY_WAIT  = 4'd8,
        S_DONE      = 4'd9
    } state_t;

    state_t             state;
    logic [ROW_W-1:0]   row;
    logic [TAP_W-1:0]   tap;
    logic [2:0]         lat;
    logic [TAP_W:0]     vcnt;
    logic [ROW_W:0]     ones;
    logic               result;
    logic               key_seen;
    logic [TAP_W:0]     vcnt_next;

    assign vcnt_next = vcnt + (TAP_W + 1)'(i_pixel_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            row      <= START_ROW;
            tap      <= '0;
            lat      <= '0;
            vcnt     <= '0;
            ones     <= '0;
            result   <= 1'b0;
            key_seen <= 1'b0;
        end else if (i_abort) begin
            // Abort wins over everything, including i_go in IDLE; counters keep partial values.
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (i_go) begin
                        row   <= START_ROW;
                        ones  <= '0;
                        state <= S_WAIT_WR;
                    end
                end
                S_WAIT_WR: begin
                    if (i_write_done) begin
                        tap   <= '0;
                        vcnt  <= '0;
                        lat   <= '0;
                        state <= S_RD;
                    end
                end
                S_RD: begin
                    if (lat == LAST_LAT) begin
                        state <= S_CMP;
                    end else begin
                        lat <= lat + 3'd1;
                    end
                end
                S_CMP: begin
                    vcnt <= vcnt_next;
                    lat  <= '0;
                    if (MODE == 0 && !i_pixel_valid) begin
                        result <= 1'b0;
                        state  <= S_WRITE;
                    end else if (MODE == 1 && i_pixel_valid) begin
                        result <= 1'b1;
                        state  <= S_WRITE;
                    end else if (tap == LAST_TAP) begin
                        if (MODE == 0)      result <= 1'b1;
                        else if (MODE == 1) result <= 1'b0;
                        else                result <= (vcnt_next > HALF_TAPS);
                        state <= S_WRITE;
                    end else begin
                        tap   <= tap + TAP_W'(1);
                        state <= S_RD;
                    end
                end
                S_WRITE: begin
                    ones  <= ones + (ROW_W + 1)'(result);
                    state <= S_NEXT;
                end
                S_NEXT: begin
                    if (row == LAST_ROW) begin
                        state <= S_WAIT_IDLE;
                    end else begin
                        row   <= (ROW_ASC != 0) ? row + ROW_W'(1) : row - ROW_W'(1);
                        state <= S_WAIT_WR;
                    end
                end
                S_WAIT_IDLE: begin
                    if (i_write_done) state <= S_KEY_REQ;
                end
                S_KEY_REQ: begin
                    // A completion that arrives in the request cycle itself must not be lost.
                    key_seen <= i_key_write_done;
                    state    <= S_KEY_WAIT;
                end
                S_KEY_WAIT: begin
                    if (key_seen || i_key_write_done) state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign o_mem_read = (state == S_RD)      && !i_abort;
    assign o_row_wren = (state == S_WRITE)   && !i_abort;
    assign o_key_wren = (state == S_KEY_REQ) && !i_abort;
    assign o_done     = (state == S_DONE)    && !i_abort;
    assign o_row_val  = result;
    assign o_busy     = (state != S_IDLE);
    assign o_row_idx  = row;
    assign o_tap_idx  = tap;
    assign o_ones_cnt = ones;

endmodule
`default_nettype wire

// File: tb/tb_row_cfg_seq.sv
`default_nettype none
// Testbench for row_cfg_seq: four differently parameterised instances driven by
// scenario tables and random pixel maps, checked against a row-by-row reference model.
module tb_row_cfg_seq;

    localparam int NI = 4;
    localparam int P_ALL = 0, P_R5T0 = 1, P_T1R03 = 2, P_MAJ = 3;

    int p_mode[NI] = '{0, 1, 2, 1};
    int p_nt[NI]   = '{2, 2, 3, 1};
    int p_lat[NI]  = '{2, 2, 3, 1};
    int p_asc[NI]  = '{0, 0, 1, 1};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       go[NI], abort[NI], pv[NI], wd[NI], kd[NI], kd_late[NI];
    logic       mem_read[NI], row_wren[NI], row_val[NI], key_wren[NI], busy[NI], done[NI];
    logic [3:0] row_idx[NI];
    logic [2:0] tap_idx[NI];
    logic [4:0] ones_cnt[NI];
    bit         pix[NI][16][8];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        row_cfg_seq #(
            .N_ROWS (16),
            .ROW_W  (4),
            .N_TAPS (g == 2 ? 3 : (g == 3 ? 1 : 2)),
            .TAP_W  (3),
            .RD_LAT (g == 2 ? 3 : (g == 3 ? 1 : 2)),
            .MODE   (g == 0 ? 0 : (g == 2 ? 2 : 1)),
            .ROW_ASC(g >= 2 ? 1 : 0)
        ) u_dut (
            .clk             (clk),
            .rst_n           (rst_n),
            .i_go            (go[g]),
            .i_abort         (abort[g]),
            .i_pixel_valid   (pv[g]),
            .i_write_done    (wd[g]),
            .i_key_write_done(kd[g]),
            .o_mem_read      (mem_read[g]),
            .o_row_idx       (row_idx[g]),
            .o_tap_idx       (tap_idx[g]),
            .o_row_wren      (row_wren[g]),
            .o_row_val       (row_val[g]),
            .o_key_wren      (key_wren[g]),
            .o_busy          (busy[g]),
            .o_done          (done[g]),
            .o_ones_cnt      (ones_cnt[g])
        );
        assign pv[g] = pix[g][row_idx[g]][tap_idx[g]];
        assign kd[g] = key_wren[g] | kd_late[g];
    end

    // Event log filled by the monitor, read by the checking code.
    int cyc = 0, wn = 0, bn = 0;
    int wrow[1024], wval[1024], wcyc[1024];
    int blen[4096], bstart[4096];
    int run[NI], run_st[NI], go_cyc[NI], key_n[NI], done_n[NI], stall_cnt[NI], kcnt[NI];
    int stall_inst = -1, stall_trig = 0, key_fast = 0;

    always @(negedge clk) begin
        cyc++;
        for (int i = 0; i < NI; i++) begin
            if (go[i]) go_cyc[i] = cyc;
            if (mem_read[i]) begin
                if (run[i] == 0) run_st[i] = cyc;
                run[i]++;
            end else if (run[i] != 0) begin
                if (bn < 4096) begin blen[bn] = run[i]; bstart[bn] = run_st[i]; bn++; end
                run[i] = 0;
            end
            if (row_wren[i]) begin
                if (wn < 1024) begin
                    wrow[wn] = int'(row_idx[i]); wval[wn] = int'(row_val[i]); wcyc[wn] = cyc; wn++;
                end
                if (i == stall_inst && int'(row_idx[i]) == stall_trig) stall_cnt[i] = 5;
            end
            wd[i] = (stall_cnt[i] == 0);
            if (stall_cnt[i] > 0) stall_cnt[i]--;
            if (key_wren[i]) begin
                key_n[i]++;
                if (key_fast == 0) kcnt[i] = 3;
            end
            kd_late[i] = (kcnt[i] == 1);
            if (kcnt[i] > 0) kcnt[i]--;
            if (done[i]) done_n[i]++;
        end
    end

    int checks = 0, errors = 0;
    int exp_row[16], exp_val[16], exp_taps[16], exp_ones;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, req, $time);
        end
    endtask

    // Reference: evaluate taps in order, stopping at the first decisive flag for AND/OR.
    task automatic model(input int i);
        int r, cnt, res, n;
        bit decided;
        exp_ones = 0;
        for (int k = 0; k < 16; k++) begin
            r = (p_asc[i] != 0) ? k : 15 - k;
            cnt = 0; res = 0; n = 0; decided = 0;
            for (int t = 0; t < p_nt[i]; t++) begin
                n = t + 1;
                cnt += int'(pix[i][r][t]);
                if (p_mode[i] == 0 && !pix[i][r][t]) begin res = 0; decided = 1; break; end
                if (p_mode[i] == 1 &&  pix[i][r][t]) begin res = 1; decided = 1; break; end
            end
            if (!decided) res = (p_mode[i] == 0) ? 1 : (p_mode[i] == 1) ? 0 : ((2 * cnt > p_nt[i]) ? 1 : 0);
            exp_row[k] = r; exp_val[k] = res; exp_taps[k] = n;
            exp_ones += res;
        end
    endtask

    task automatic set_pat(input int i, input int p);
        for (int r = 0; r < 16; r++)
            for (int t = 0; t < 8; t++) begin
                case (p)
                    P_ALL:   pix[i][r][t] = 1'b1;
                    P_R5T0:  pix[i][r][t] = !(r == 5 && t == 0);
                    P_T1R03: pix[i][r][t] = (r < 4 && t == 1);
                    default: pix[i][r][t] = (r % 2 == 0) ? (t == 0 || t == 2) : (t == 1);
                endcase
            end
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    task automatic run_sweep(input int i, input int tbl_ones, input int stall);
        int w0, b0, k0, d0, nw, nb, tot, idx;
        bit got;
        model(i);
        stall_trig = exp_row[1];
        stall_inst = (stall != 0) ? i : -1;
        w0 = wn; b0 = bn; k0 = key_n[i]; d0 = done_n[i];
        @(posedge clk); #1 go[i] = 1'b1;
        @(posedge clk); #1 go[i] = 1'b0;
        got = 0;
        for (int c = 0; c < 4000 && !got; c++) begin
            @(negedge clk);
            if (done_n[i] != d0) got = 1;
        end
        chk("sweep_done_seen", int'(got), 1);
        @(posedge clk); #1;
        chk("idle_after_done", int'(busy[i]), 0);
        nw = wn - w0; nb = bn - b0;
        chk("row_write_count", nw, 16);
        for (int j = 0; j < 16 && j < nw; j++) begin
            chk("row_write_idx", wrow[w0 + j], exp_row[j]);
            chk("row_write_val", wval[w0 + j], exp_val[j]);
        end
        tot = 0;
        for (int j = 0; j < 16; j++) tot += exp_taps[j];
        chk("read_burst_count", nb, tot);
        for (int j = 0; j < nb && j < tot; j++) chk("read_burst_len", blen[b0 + j], p_lat[i]);
        if (nb > 0) chk("go_to_first_read", bstart[b0] - go_cyc[i], 2);
        idx = b0 + exp_taps[0];
        for (int j = 1; j < 16; j++) begin
            if (idx < bn && j - 1 < nw)
                chk("write_to_next_read", bstart[idx] - wcyc[w0 + j - 1], (stall != 0 && j == 2) ? 6 : 3);
            idx += exp_taps[j];
        end
        chk("key_wren_count", key_n[i] - k0, 1);
        chk("done_count", done_n[i] - d0, 1);
        chk("ones_cnt_model", int'(ones_cnt[i]), exp_ones);
        if (tbl_ones >= 0) chk("ones_cnt_expected", int'(ones_cnt[i]), tbl_ones);
        stall_inst = -1;
        if (!got) do_reset();
    endtask

    typedef struct {
        int inst;
        int pat;
        int stall;
        int kfast;
        int ones;
    } scen_t;
    scen_t tbl[6];

    initial begin
        int w0, d0, k0;
        tbl[0] = '{0, P_ALL,   0, 0, 16};
        tbl[1] = '{0, P_R5T0,  0, 1, 15};
        tbl[2] = '{1, P_T1R03, 0, 0, 4};
        tbl[3] = '{2, P_MAJ,   1, 0, 8};
        tbl[4] = '{1, P_ALL,   0, 1, 16};
        tbl[5] = '{3, P_ALL,   1, 0, 16};

        rst_n = 1'b0;
        for (int i = 0; i < NI; i++) begin
            go[i] = 1'b0; abort[i] = 1'b0; set_pat(i, P_ALL);
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", int'(busy[i]), 0);
            chk("rst_row_idx", int'(row_idx[i]), (p_asc[i] != 0) ? 0 : 15);
            chk("rst_tap_idx", int'(tap_idx[i]), 0);
            chk("rst_ones", int'(ones_cnt[i]), 0);
            chk("rst_strobes", int'({mem_read[i], row_wren[i], key_wren[i], done[i]}), 0);
        end
        rst_n = 1'b1;

        foreach (tbl[s]) begin
            set_pat(tbl[s].inst, tbl[s].pat);
            key_fast = tbl[s].kfast;
            run_sweep(tbl[s].inst, tbl[s].ones, tbl[s].stall);
        end

        // Abort in row 7's WRITE cycle: 9-cycle rows, WRITE is the 8th cycle after go is taken.
        set_pat(0, P_ALL);
        key_fast = 0;
        w0 = wn; d0 = done_n[0]; k0 = key_n[0];
        @(posedge clk); #1 go[0] = 1'b1;
        @(posedge clk); #1 go[0] = 1'b0;
        repeat (79) @(posedge clk);
        #1;
        chk("abort_pre_wren", int'(row_wren[0]), 1);
        chk("abort_pre_row", int'(row_idx[0]), 7);
        abort[0] = 1'b1;
        #1 chk("abort_wren_suppressed", int'(row_wren[0]), 0);
        @(posedge clk); #1 abort[0] = 1'b0;
        chk("abort_busy_low", int'(busy[0]), 0);
        repeat (20) @(posedge clk);
        #1;
        chk("abort_writes", wn - w0, 8);
        chk("abort_no_done", done_n[0] - d0, 0);
        chk("abort_no_key", key_n[0] - k0, 0);
        chk("abort_ones_partial", int'(ones_cnt[0]), 8);
        chk("abort_still_idle", int'(busy[0]), 0);
        run_sweep(0, 16, 0);

        // go and abort together in IDLE: abort wins.
        @(posedge clk); #1 go[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1 go[0] = 1'b0; abort[0] = 1'b0;
        chk("go_abort_idle", int'(busy[0]), 0);
        @(posedge clk); #1 chk("go_abort_idle_hold", int'(busy[0]), 0);

        // Asynchronous reset mid-sweep on the ascending majority instance.
        set_pat(2, P_ALL);
        @(posedge clk); #1 go[2] = 1'b1;
        @(posedge clk); #1 go[2] = 1'b0;
        repeat (40) @(posedge clk);
        #1 chk("mid_ones_nonzero", int'(ones_cnt[2] != 0), 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", int'(busy[2]), 0);
        chk("mid_rst_strobes", int'({mem_read[2], row_wren[2], key_wren[2], done[2]}), 0);
        chk("mid_rst_row", int'(row_idx[2]), 0);
        chk("mid_rst_ones", int'(ones_cnt[2]), 0);
        @(posedge clk); #1 rst_n = 1'b1;

        for (int k = 0; k < 8; k++) begin
            int i;
            i = k % NI;
            for (int r = 0; r < 16; r++)
                for (int t = 0; t < 8; t++)
                    pix[i][r][t] = (p_mode[i] == 0) ? ($urandom_range(0, 5) != 0) :
                                   (p_mode[i] == 1) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 1) == 1);
            key_fast = int'($urandom_range(0, 1));
            run_sweep(i, -1, (p_asc[i] != 0) ? int'($urandom_range(0, 1)) : 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
